// File: rtl/mux2_rr_stream_arb.sv
// Two-input round-robin stream arbiter. A grant is held for a whole packet
// (until a beat with last transfers), the winning beat is registered into a
// one-stage output register, and completed packets are counted per source.
module mux2_rr_stream_arb #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s0_valid,
  output logic              s0_ready,
  input  logic [DATA_W-1:0] s0_data,
  input  logic              s0_last,
  input  logic              s1_valid,
  output logic              s1_ready,
  input  logic [DATA_W-1:0] s1_data,
  input  logic              s1_last,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  output logic              sel,
  output logic              busy,
  output logic [CNT_W-1:0]  pkt_cnt0,
  output logic [CNT_W-1:0]  pkt_cnt1
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_t;

  state_t            state_reg, state_next;
  logic              prio_reg, prio_next;
  logic              sel_reg, sel_next;
  logic              m_valid_reg, m_valid_next;
  logic [DATA_W-1:0] m_data_reg, m_data_next;
  logic              m_last_reg, m_last_next;

  // The output register can take a new beat when it is empty or being drained.
  logic              out_free;

  // Per-source views so both sources share one code path.
  logic [1:0]        src_valid;
  logic [1:0]        src_last;
  logic [1:0]        src_ready;
  logic [1:0]        src_xfer;
  logic [1:0]        pkt_done;
  logic [DATA_W-1:0] src_data [2];

  assign out_free    = !m_valid_reg || m_ready;
  assign src_valid   = {s1_valid, s0_valid};
  assign src_last    = {s1_last, s0_last};
  assign src_data[0] = s0_data;
  assign src_data[1] = s1_data;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_src
      localparam state_t GRANT_ST = (gi == 0) ? GRANT0 : GRANT1;
      logic [CNT_W-1:0] cnt_reg;

      // Ready depends only on ownership and room in the output register,
      // never on the source's own valid.
      assign src_ready[gi] = (state_reg == GRANT_ST) && out_free;
      assign src_xfer[gi]  = src_valid[gi] && src_ready[gi];
      assign pkt_done[gi]  = src_xfer[gi] && src_last[gi];

      // Completed-packet counter; wraps naturally at 2^CNT_W.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt_reg <= '0;
        end else if (pkt_done[gi]) begin
          cnt_reg <= cnt_reg + CNT_W'(1);
        end
      end
    end
  endgenerate

  // Next-state, grant and output-register update.
  always_comb begin
    state_next   = state_reg;
    prio_next    = prio_reg;
    sel_next     = sel_reg;
    m_valid_next = m_valid_reg;
    m_data_next  = m_data_reg;
    m_last_next  = m_last_reg;

    // A beat leaving downstream empties the register unless refilled below.
    if (m_ready) begin
      m_valid_next = 1'b0;
    end

    unique case (state_reg)
      IDLE: begin
        // One arbitration cycle; nothing is accepted while deciding.
        if (src_valid[0] && src_valid[1]) begin
          state_next = prio_reg ? GRANT1 : GRANT0;
          sel_next   = prio_reg;
        end else if (src_valid[0]) begin
          state_next = GRANT0;
          sel_next   = 1'b0;
        end else if (src_valid[1]) begin
          state_next = GRANT1;
          sel_next   = 1'b1;
        end
      end
      GRANT0, GRANT1: begin
        // sel_reg always names the owner while granted.
        if (src_xfer[sel_reg]) begin
          m_valid_next = 1'b1;
          m_data_next  = src_data[sel_reg];
          m_last_next  = src_last[sel_reg];
          if (src_last[sel_reg]) begin
            state_next = IDLE;
            prio_next  = ~sel_reg;
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State and output registers; reset discards any in-flight beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      prio_reg    <= 1'b0;
      sel_reg     <= 1'b0;
      m_valid_reg <= 1'b0;
      m_data_reg  <= '0;
      m_last_reg  <= 1'b0;
    end else begin
      state_reg   <= state_next;
      prio_reg    <= prio_next;
      sel_reg     <= sel_next;
      m_valid_reg <= m_valid_next;
      m_data_reg  <= m_data_next;
      m_last_reg  <= m_last_next;
    end
  end

  assign s0_ready = src_ready[0];
  assign s1_ready = src_ready[1];
  assign m_valid  = m_valid_reg;
  assign m_data   = m_data_reg;
  assign m_last   = m_last_reg;
  assign sel      = sel_reg;
  assign busy     = (state_reg != IDLE);
  assign pkt_cnt0 = g_src[0].cnt_reg;
  assign pkt_cnt1 = g_src[1].cnt_reg;

endmodule

// File: tb/tb_mux2_rr_stream_arb.sv
// Testbench for mux2_rr_stream_arb: directed reset/latency checks, then
// randomized packet traffic checked by a packet-level arbitration model and a
// scoreboard of expected output beats popped by an independent monitor.
module tb_mux2_rr_stream_arb;
  localparam int DATA_W = 8;
  localparam int CNT_W  = 2;
  localparam int CNT_MOD = 1 << CNT_W;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              s0_valid, s0_ready, s0_last;
  logic [DATA_W-1:0] s0_data;
  logic              s1_valid, s1_ready, s1_last;
  logic [DATA_W-1:0] s1_data;
  logic              m_valid, m_ready, m_last;
  logic [DATA_W-1:0] m_data;
  logic              sel, busy;
  logic [CNT_W-1:0]  pkt_cnt0, pkt_cnt1;

  mux2_rr_stream_arb #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .s0_valid(s0_valid), .s0_ready(s0_ready), .s0_data(s0_data), .s0_last(s0_last),
    .s1_valid(s1_valid), .s1_ready(s1_ready), .s1_data(s1_data), .s1_last(s1_last),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .sel(sel), .busy(busy), .pkt_cnt0(pkt_cnt0), .pkt_cnt1(pkt_cnt1)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic              last;
    logic [DATA_W-1:0] data;
  } beat_t;

  int    n_checks = 0;
  int    n_fail   = 0;
  beat_t exp_q[$];
  beat_t sq0[$];
  beat_t sq1[$];
  bit    mon_en = 1'b0;

  // Packet-level reference: who owns the path (-1 = arbitrating), who wins
  // the next tie, and how many packets each source has completed.
  int mdl_owner;
  bit mdl_prio;
  int mdl_cnt0, mdl_cnt1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic gen_pkt(input int src);
    beat_t b;
    int    len;
    len = $urandom_range(4, 1);
    for (int i = 0; i < len; i++) begin
      b.data = DATA_W'($urandom);
      b.last = (i == len - 1);
      if (src == 0) sq0.push_back(b);
      else          sq1.push_back(b);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_m_valid"}, m_valid, 0);
    chk({tag, "_m_data"}, m_data, 0);
    chk({tag, "_m_last"}, m_last, 0);
    chk({tag, "_sel"}, sel, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_cnt0"}, pkt_cnt0, 0);
    chk({tag, "_cnt1"}, pkt_cnt1, 0);
  endtask

  // One cycle per iteration: observe at negedge, update model, drive after posedge.
  task automatic run(input int ncyc, input int pv, input int pr, input bit refill);
    logic  v0, v1, r0, r1, a0, a1, ofree, acc;
    beat_t b;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      v0 = s0_valid; v1 = s1_valid; r0 = s0_ready; r1 = s1_ready;
      a0 = v0 && r0; a1 = v1 && r1;
      ofree = !m_valid || m_ready;
      chk("pkt_cnt0", pkt_cnt0, mdl_cnt0 % CNT_MOD);
      chk("pkt_cnt1", pkt_cnt1, mdl_cnt1 % CNT_MOD);
      if (mdl_owner < 0) begin
        chk("idle_busy", busy, 0);
        chk("idle_ready", {r1, r0}, 0);
        if (v0 || v1) mdl_owner = (v0 && v1) ? int'(mdl_prio) : (v1 ? 1 : 0);
      end else begin
        chk("grant_sel", sel, mdl_owner);
        chk("grant_busy", busy, 1);
        if (mdl_owner == 0) begin
          chk("ready0_owner", r0, ofree);
          chk("ready1_other", r1, 0);
          acc = a0;
        end else begin
          chk("ready1_owner", r1, ofree);
          chk("ready0_other", r0, 0);
          acc = a1;
        end
        if (acc) begin
          if (mdl_owner == 0) b = sq0.pop_front();
          else                b = sq1.pop_front();
          exp_q.push_back(b);
          if (b.last) begin
            if (mdl_owner == 0) mdl_cnt0++;
            else                mdl_cnt1++;
            mdl_prio  = (mdl_owner == 0);
            mdl_owner = -1;
          end
        end
      end
      @(posedge clk);
      #1;
      if (!v0 || a0) begin
        if (refill && sq0.size() == 0) gen_pkt(0);
        if (sq0.size() > 0 && $urandom_range(99) < pv) begin
          s0_valid = 1'b1; {s0_last, s0_data} = sq0[0];
        end else begin
          s0_valid = 1'b0; s0_data = DATA_W'($urandom); s0_last = 1'($urandom);
        end
      end
      if (!v1 || a1) begin
        if (refill && sq1.size() == 0) gen_pkt(1);
        if (sq1.size() > 0 && $urandom_range(99) < pv) begin
          s1_valid = 1'b1; {s1_last, s1_data} = sq1[0];
        end else begin
          s1_valid = 1'b0; s1_data = DATA_W'($urandom); s1_last = 1'($urandom);
        end
      end
      m_ready = ($urandom_range(99) < pr);
    end
  endtask

  task automatic drain(input string tag);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      run(1, 100, 100, 1'b0);
      done = (sq0.size() == 0) && (sq1.size() == 0) && (exp_q.size() == 0) && !m_valid;
    end
    chk({tag, "_drained"}, done, 1);
  endtask

  // Output monitor: pops the scoreboard on every output handshake and checks
  // that a stalled beat stays put.
  initial begin
    logic              stall_prev;
    logic [DATA_W-1:0] data_prev;
    logic              last_prev;
    beat_t             e;
    stall_prev = 1'b0;
    data_prev  = '0;
    last_prev  = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n || !mon_en) begin
        stall_prev = 1'b0;
      end else begin
        if (stall_prev) begin
          chk("hold_valid", m_valid, 1);
          chk("hold_data", m_data, data_prev);
          chk("hold_last", m_last, last_prev);
        end
        if (m_valid && m_ready) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL out_unexpected: got beat 0x%0h, required no beat", m_data);
          end else begin
            e = exp_q.pop_front();
            chk("out_data", m_data, e.data);
            chk("out_last", m_last, e.last);
            $display("out beat data=0x%02h last=%0b sel=%0b", m_data, m_last, sel);
          end
        end
        stall_prev = m_valid && !m_ready;
        data_prev  = m_data;
        last_prev  = m_last;
      end
    end
  end

  initial begin
    beat_t b;
    rst_n = 1'b0;
    s0_valid = 1'b0; s0_data = '0; s0_last = 1'b0;
    s1_valid = 1'b0; s1_data = '0; s1_last = 1'b0;
    m_ready = 1'b0;

    // Reset held with random inputs: everything stays cleared.
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      s0_valid = 1'($urandom); s0_data = DATA_W'($urandom); s0_last = 1'($urandom);
      s1_valid = 1'($urandom); s1_data = DATA_W'($urandom); s1_last = 1'($urandom);
      m_ready  = 1'($urandom);
      @(negedge clk);
      chk_all_zero("rst");
      chk("rst_ready", {s1_ready, s0_ready}, 0);
    end
    @(posedge clk); #1;
    s0_valid = 1'b0; s1_valid = 1'b0; m_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;

    // Directed 3-beat packet from source 0 with m_ready=1.
    @(posedge clk); #1;
    s0_valid = 1'b1; s0_data = 8'h11; s0_last = 1'b0;
    @(negedge clk);
    chk("p1_c0_busy", busy, 0);
    chk("p1_c0_ready", s0_ready, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("p1_c1_sel", sel, 0);
    chk("p1_c1_busy", busy, 1);
    chk("p1_c1_ready", s0_ready, 1);
    chk("p1_c1_mvalid", m_valid, 0);
    @(posedge clk); #1;
    s0_data = 8'h22;
    @(negedge clk);
    chk("p1_c2_valid", m_valid, 1);
    chk("p1_c2_data", m_data, 8'h11);
    chk("p1_c2_last", m_last, 0);
    @(posedge clk); #1;
    s0_data = 8'h33; s0_last = 1'b1;
    @(negedge clk);
    chk("p1_c3_data", m_data, 8'h22);
    chk("p1_c3_last", m_last, 0);
    @(posedge clk); #1;
    s0_valid = 1'b0; s0_last = 1'b0;
    @(negedge clk);
    chk("p1_c4_data", m_data, 8'h33);
    chk("p1_c4_last", m_last, 1);
    chk("p1_c4_cnt0", pkt_cnt0, 1);
    chk("p1_c4_busy", busy, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("p1_c5_mvalid", m_valid, 0);

    // Model now: idle, source 1 preferred, one source-0 packet done.
    mdl_owner = -1; mdl_prio = 1'b1; mdl_cnt0 = 1; mdl_cnt1 = 0;
    mon_en = 1'b1;

    // Both sources continuously valid with single-beat packets: strict alternation.
    for (int i = 0; i < 4; i++) begin
      b.last = 1'b1;
      b.data = DATA_W'(8'hA0 + i); sq0.push_back(b);
      b.data = DATA_W'(8'hB0 + i); sq1.push_back(b);
    end
    run(24, 100, 100, 1'b0);
    drain("alt");
    chk("alt_cnt0", pkt_cnt0, (1 + 4) % CNT_MOD);
    chk("alt_cnt1", pkt_cnt1, 4 % CNT_MOD);

    // Random traffic: gaps, backpressure, multi-beat packets, counter wrap.
    run(3000, 70, 70, 1'b1);
    drain("rand");

    // Asynchronous reset in the middle of traffic.
    run(40, 85, 50, 1'b1);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk_all_zero("arst");
    exp_q.delete(); sq0.delete(); sq1.delete();
    s0_valid = 1'b0; s1_valid = 1'b0; m_ready = 1'b1;
    mdl_owner = -1; mdl_prio = 1'b0; mdl_cnt0 = 0; mdl_cnt1 = 0;
    @(negedge clk);
    chk("arst_busy_hold", busy, 0);
    rst_n = 1'b1;

    // Recovery after reset.
    run(400, 75, 60, 1'b1);
    drain("post");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mux2_rr_stream_arb.md
Name: mux2_rr_stream_arb

Overview:
- Two-input round-robin stream arbiter; the packet-aware, sequential stage directly upstream of the combinational 2:1 mux.
- Decides which of two valid/ready sources owns the path and holds that grant for a whole packet (until a beat with last).
- Drives the mux select as `sel` and registers the selected beat into a one-stage output register.
- Keeps per-source completed-packet counters for debug and verification.

Parameters:
- DATA_W, 8, payload width of s0_data, s1_data and m_data.
- CNT_W, 8, width of the per-source completed-packet counters; counters wrap modulo 2^CNT_W.

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous active-low reset; assertion clears all state immediately, release is synchronous to clk.
- s0_valid  input  1  source 0 beat valid.
- s0_ready  output  1  source 0 beat accepted this cycle (combinational).
- s0_data  input  DATA_W  source 0 payload.
- s0_last  input  1  source 0 final beat of packet.
- s1_valid  input  1  source 1 beat valid.
- s1_ready  output  1  source 1 beat accepted this cycle (combinational).
- s1_data  input  DATA_W  source 1 payload.
- s1_last  input  1  source 1 final beat of packet.
- m_valid  output  1  output beat valid (registered).
- m_ready  input  1  downstream accepts the output beat.
- m_data  output  DATA_W  output payload (registered).
- m_last  output  1  output final-beat flag (registered).
- sel  output  1  current grant, 0 = source 0, 1 = source 1 (registered); drives the downstream mux select.
- busy  output  1  high when state is GRANT0 or GRANT1.
- pkt_cnt0  output  CNT_W  number of completed source 0 packets.
- pkt_cnt1  output  CNT_W  number of completed source 1 packets.

Behaviour:
- Reset values: state=IDLE, prio=0 (source 0 preferred), sel=0, busy=0, m_valid=0, m_data=0, m_last=0, pkt_cnt0=0, pkt_cnt1=0.
- Reset has the same effect mid-packet; the in-flight beat is discarded.
- Definition: out_free = !m_valid || m_ready.
- State IDLE:
  - Both s*_ready are 0.
  - If exactly one s*_valid is high, the next state is GRANTx for that source.
  - If both are high, the next state is GRANT[prio].
  - sel is loaded with the chosen index on the same edge.
  - If neither valid is high, stay in IDLE and hold sel.
  - IDLE always costs exactly one arbitration cycle.
- State GRANTx:
  - sx_ready = sx_valid-independent out_free; the other source's ready is 0.
  - A beat transfers when sx_valid && sx_ready; on that edge m_data<=sx_data, m_last<=sx_last, m_valid<=1.
  - If no beat transfers and m_ready is high, m_valid<=0.
  - While m_valid && !m_ready, m_data and m_last hold stable and no source is accepted.
  - The grant is held while sx_valid is low mid-packet; the other source is never granted mid-packet.
- Packet end: on a transferred beat with sx_last=1, on that edge:
  - state<=IDLE;
  - prio<=~x;
  - pkt_cntx increments (wrapping from 2^CNT_W-1 to 0).
- sel changes only on an IDLE->GRANT edge.
- Latency: first beat of a packet appears on m_valid 2 cycles after sx_valid rises from IDLE with m_ready=1; subsequent beats follow at 1 beat/cycle.
- Throughput: single-source streaming sustains 1 beat/cycle within a packet, with a 1-cycle bubble between packets.
- A single-beat packet (last on first beat) is legal: GRANT lasts one cycle.

Test Plan:
- Reset: hold rst_n=0 with random inputs -> all outputs 0 and sel=0; assert rst_n=0 asynchronously mid-packet (between clock edges) -> m_valid falls immediately and state returns to IDLE.
- s0 only, 3 beats 0x11,0x22,0x33 (last on 0x33), m_ready=1 -> sel=0 from cycle 1; m_data 0x11/0x22/0x33 on cycles 2/3/4 with m_last only on 0x33; pkt_cnt0=1; prio=1.
- Both sources valid from reset, each sending 1-beat packets (s0=0xA0.., s1=0xB0..) -> grant order s0,s1,s0,s1; each IDLE cycle visible as busy=0; pkt_cnt0=pkt_cnt1 after each pair.
- Backpressure: m_ready=0 for 4 cycles while m_valid=1, m_data=0x22 -> m_data holds 0x22; s0_ready=0; no beat lost or duplicated after m_ready returns to 1.
- Mid-packet gap: s1 granted, s1_valid drops 3 cycles before last while s0_valid=1 -> sel stays 1 and s0_ready stays 0 until s1's last beat transfers; s0 is then granted.
- Counter wrap with CNT_W=2: five s1 packets -> pkt_cnt1 sequence 1,2,3,0,1.
